// File: rtl/toggle_meter.sv
// Switching-activity monitor: counts bit toggles on d between enabled samples,
// accumulates them over a fixed window and reports the window total and per-sample peak.
module toggle_meter #(
    parameter int WIDTH  = 32,
    parameter int WINDOW = 64,
    parameter int CW     = 16,
    parameter int PW     = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [CW-1:0]    total,
    output logic [PW-1:0]    peak,
    output logic             ovf,
    output logic             valid
);

    typedef enum logic [0:0] {
        PRIME = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam int             CNTW     = 16;
    localparam logic [CNTW-1:0] LAST_CNT = CNTW'(WINDOW - 1);

    function automatic logic [PW-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [PW-1:0] n;
        n = {PW{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            n = n + {{(PW-1){1'b0}}, v[i]};
        end
        return n;
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] prev_r;
    logic [CW-1:0]    acc_r;
    logic [PW-1:0]    runmax_r;
    logic [CNTW-1:0]  cnt_r;
    logic             wovf_r;
    logic [CW-1:0]    total_r;
    logic [PW-1:0]    peak_r;
    logic             ovf_r;
    logic             valid_r;

    logic [PW-1:0]    tog_s;
    logic [CW:0]      sum_s;
    logic             sat_s;
    logic [CW-1:0]    acc_sat_s;
    logic [PW-1:0]    max_s;
    logic             close_s;
    logic             count_s;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= PRIME;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: leave PRIME on the first enabled sample, RUN is absorbing
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            PRIME: begin
                if (en) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = PRIME;
                end
            end
            RUN:     state_nxt_s = RUN;
            default: state_nxt_s = PRIME;
        endcase
    end

    // Toggle count, saturating accumulate, running max and window-close detect
    always_comb begin
        tog_s = popcount(d ^ prev_r);
        sum_s = {1'b0, acc_r} + {{(CW+1-PW){1'b0}}, tog_s};
        sat_s = sum_s[CW];
        if (sat_s) begin
            acc_sat_s = {CW{1'b1}};
        end else begin
            acc_sat_s = sum_s[CW-1:0];
        end
        if (tog_s > runmax_r) begin
            max_s = tog_s;
        end else begin
            max_s = runmax_r;
        end
        close_s = (cnt_r == LAST_CNT);
        if ((state_r == RUN) && en) begin
            count_s = 1'b1;
        end else begin
            count_s = 1'b0;
        end
    end

    // Window datapath and registered results; prev loads on every enabled edge,
    // including the priming one and the window-closing one
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_r   <= {WIDTH{1'b0}};
            acc_r    <= {CW{1'b0}};
            runmax_r <= {PW{1'b0}};
            cnt_r    <= {CNTW{1'b0}};
            wovf_r   <= 1'b0;
            total_r  <= {CW{1'b0}};
            peak_r   <= {PW{1'b0}};
            ovf_r    <= 1'b0;
            valid_r  <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            if (en) begin
                prev_r <= d;
            end
            if (count_s) begin
                if (close_s) begin
                    total_r  <= acc_sat_s;
                    peak_r   <= max_s;
                    ovf_r    <= wovf_r | sat_s;
                    valid_r  <= 1'b1;
                    acc_r    <= {CW{1'b0}};
                    runmax_r <= {PW{1'b0}};
                    cnt_r    <= {CNTW{1'b0}};
                    wovf_r   <= 1'b0;
                end else begin
                    acc_r    <= acc_sat_s;
                    runmax_r <= max_s;
                    cnt_r    <= cnt_r + 16'd1;
                    wovf_r   <= wovf_r | sat_s;
                end
            end
        end
    end

    assign total = total_r;
    assign peak  = peak_r;
    assign ovf   = ovf_r;
    assign valid = valid_r;

endmodule

// File: tb/tb_toggle_meter.sv
// Scoreboard bench for toggle_meter: three instances (WINDOW=4, default, CW=8),
// expected results queued at stimulus time and popped by per-instance monitors.
module tb_toggle_meter;

    typedef struct {
        logic [15:0] tot;
        logic [5:0]  pk;
        logic        ov;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        reset;
    int          edge_n;
    int          total_n;
    int          bad_n;

    logic        en_a, en_b, en_c;
    logic [31:0] d_a, d_b, d_c;
    logic [15:0] total_a, total_b;
    logic [7:0]  total_c;
    logic [5:0]  peak_a, peak_b, peak_c;
    logic        ovf_a, ovf_b, ovf_c;
    logic        valid_a, valid_b, valid_c;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];

    toggle_meter #(.WIDTH(32), .WINDOW(4), .CW(16), .PW(6)) u_a (
        .clk(clk), .reset(reset), .en(en_a), .d(d_a),
        .total(total_a), .peak(peak_a), .ovf(ovf_a), .valid(valid_a)
    );

    toggle_meter #(.WIDTH(32), .WINDOW(64), .CW(16), .PW(6)) u_b (
        .clk(clk), .reset(reset), .en(en_b), .d(d_b),
        .total(total_b), .peak(peak_b), .ovf(ovf_b), .valid(valid_b)
    );

    toggle_meter #(.WIDTH(32), .WINDOW(64), .CW(8), .PW(6)) u_c (
        .clk(clk), .reset(reset), .en(en_c), .d(d_c),
        .total(total_c), .peak(peak_c), .ovf(ovf_c), .valid(valid_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    function automatic void chk(input string nm, input longint act, input longint exp_v);
        total_n++;
        if (act != exp_v) begin
            bad_n++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endfunction

    function automatic void score(input string tag, input logic [15:0] t, input logic [5:0] p,
                                  input logic o, input exp_t e);
        chk({tag, "_total"}, t, e.tot);
        chk({tag, "_peak"}, p, e.pk);
        chk({tag, "_ovf"}, o, e.ov);
        chk({tag, "_valid_edge"}, edge_n, e.cyc);
    endfunction

    function automatic void spurious(input string tag);
        total_n++;
        bad_n++;
        $display("FAIL %s_valid: pulse at edge %0d, expected no pulse", tag, edge_n);
    endfunction

    // Monitors: sample outputs on the falling edge, pop and compare on each valid pulse
    always @(negedge clk) begin
        exp_t e;
        if (valid_a === 1'b1) begin
            if (qa.size() == 0) spurious("a");
            else begin
                e = qa.pop_front();
                score("a", total_a, peak_a, ovf_a, e);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (valid_b === 1'b1) begin
            if (qb.size() == 0) spurious("b");
            else begin
                e = qb.pop_front();
                score("b", total_b, peak_b, ovf_b, e);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (valid_c === 1'b1) begin
            if (qc.size() == 0) spurious("c");
            else begin
                e = qc.pop_front();
                score("c", {8'd0, total_c}, peak_c, ovf_c, e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        int p;
        int g;
        edge_n  = 0;
        total_n = 0;
        bad_n   = 0;
        reset   = 1'b0;
        en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
        d_a = 32'd0; d_b = 32'd0; d_c = 32'd0;

        repeat (3) tick();
        chk("rst_total_b", total_b, 0);
        chk("rst_peak_b", peak_b, 0);
        chk("rst_ovf_b", ovf_b, 0);
        chk("rst_valid_b", valid_b, 0);
        chk("rst_total_a", total_a, 0);
        chk("rst_valid_c", valid_c, 0);
        reset = 1'b1;
        tick();

        // WINDOW=4, d=0..4: toggles 1,2,1,3
        en_a = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            d_a = 32'(i);
            if (i == 4) qa.push_back('{tot: 16'd7, pk: 6'd3, ov: 1'b0, cyc: edge_n + 1});
            tick();
        end
        en_a = 1'b0;
        repeat (3) tick();

        // Free-running counter 0..128: windows 127/7 and 128/8, 64 edges apart
        en_b = 1'b1;
        p = edge_n + 1;
        qb.push_back('{tot: 16'd127, pk: 6'd7, ov: 1'b0, cyc: p + 64});
        qb.push_back('{tot: 16'd128, pk: 6'd8, ov: 1'b0, cyc: p + 128});
        for (int i = 0; i <= 128; i++) begin
            d_b = 32'(i);
            tick();
        end
        en_b = 1'b0;
        repeat (3) tick();

        // Same counter window with a 5-cycle enable gap: result shifted by 5 edges
        do_reset();
        en_b = 1'b1;
        g = $urandom_range(10, 50);
        p = edge_n + 1;
        qb.push_back('{tot: 16'd127, pk: 6'd7, ov: 1'b0, cyc: p + 64 + 5});
        for (int i = 0; i <= 64; i++) begin
            if (i == g) begin
                en_b = 1'b0;
                repeat (5) tick();
                en_b = 1'b1;
            end
            d_b = 32'(i);
            tick();
        end

        // 30 samples into the next window, then an asynchronous reset between edges
        for (int i = 65; i <= 94; i++) begin
            d_b = 32'(i);
            tick();
        end
        #2;
        reset = 1'b0;
        #1;
        chk("async_total_b", total_b, 0);
        chk("async_peak_b", peak_b, 0);
        chk("async_ovf_b", ovf_b, 0);
        chk("async_valid_b", valid_b, 0);
        tick();
        chk("inrst_total_b", total_b, 0);
        chk("inrst_valid_b", valid_b, 0);
        reset = 1'b1;
        p = edge_n + 1;
        qb.push_back('{tot: 16'd127, pk: 6'd7, ov: 1'b0, cyc: p + 64});
        for (int i = 0; i <= 64; i++) begin
            d_b = 32'(i);
            tick();
        end
        en_b = 1'b0;
        repeat (3) tick();

        // CW=8: alternating all-zero/all-one saturates, then a constant window clears
        en_c = 1'b1;
        p = edge_n + 1;
        qc.push_back('{tot: 16'd255, pk: 6'd32, ov: 1'b1, cyc: p + 64});
        qc.push_back('{tot: 16'd0, pk: 6'd0, ov: 1'b0, cyc: p + 128});
        for (int i = 0; i <= 64; i++) begin
            d_c = (i % 2 == 1) ? 32'hFFFF_FFFF : 32'h0000_0000;
            tick();
        end
        for (int i = 0; i < 64; i++) begin
            d_c = 32'h0000_0000;
            tick();
        end
        en_c = 1'b0;
        repeat (5) tick();

        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);
        chk("qc_drained", qc.size(), 0);

        $display("test done: total=%0d bad=%0d", total_n, bad_n);
        $finish;
    end

endmodule
